// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scan sequencer for a 4x4 active-low matrix keypad. One row is driven low
// at a time; after a settle period the synchronized columns are sampled. A
// non-idle sample is debounced, accepted once, and then locked out until the
// key has been released for a full debounce window. Accepted codes feed a
// two-digit history for the seven-segment display path.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   columns   : keypad columns, active-low, asynchronous to clk
//   rows      : one-cold row strobes
//   key_code  : hex code of the last accepted key
//   key_valid : one-cycle pulse per accepted press
//   digit_new : most recent accepted key
//   digit_old : key accepted before digit_new
//   busy      : high while debouncing, accepting or waiting for release
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 4800,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       COL_IDLE    = 4'b1111;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, HOLD} state_t;

  state_t           state;
  logic [1:0]       r;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cap;
  logic [3:0]       col_p0;
  logic [3:0]       col_p1;
  logic [3:0]       col_s;

  assign col_s = col_p1;

  // Lowest column index with a low level wins when several are pressed.
  function automatic logic [1:0] lowest_zero(input logic [3:0] cols);
    logic [1:0] idx;
    if (!cols[0])      idx = 2'd0;
    else if (!cols[1]) idx = 2'd1;
    else if (!cols[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [3:0] cols);
    logic [3:0] code;
    code = 4'h0;
    case ({row, lowest_zero(cols)})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Synchronizer stages p0 -> p1; idle level is all-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_p0 <= COL_IDLE;
      col_p1 <= COL_IDLE;
    end else begin
      col_p0 <= columns;
      col_p1 <= col_p0;
    end
  end

  // Sequencer. rows is kept as a rotating register alongside r so the strobe
  // comes straight from a flop and can never show zero or two low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      r         <= 2'd0;
      rows      <= 4'b1110;
      cnt       <= '0;
      cap       <= COL_IDLE;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
      busy      <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (col_s == COL_IDLE) begin
              r    <= r + 2'd1;
              rows <= {rows[2:0], rows[3]};
            end else begin
              cap   <= col_s;
              state <= DEBOUNCE;
              busy  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s != cap) begin
            // Any change restarts the window; a full release abandons it.
            cnt <= '0;
            if (col_s == COL_IDLE) begin
              state <= SCAN;
              busy  <= 1'b0;
              r     <= r + 2'd1;
              rows  <= {rows[2:0], rows[3]};
            end
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= PRESSED;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          key_code  <= decode_key(r, cap);
          digit_new <= decode_key(r, cap);
          digit_old <= digit_new;
          key_valid <= 1'b1;
          cnt       <= '0;
          state     <= HOLD;
        end
        HOLD: begin
          if (col_s != COL_IDLE) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= SCAN;
            busy  <= 1'b0;
            r     <= r + 2'd1;
            rows  <= {rows[2:0], rows[3]};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SETTLE_CYCLES=4, DEBOUNCE_CYCLES=16.
// A small keypad model pulls a column low when a pressed key's row is driven.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] columns;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       busy;
  logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c pressed

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES(4),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .columns(columns),
    .rows(rows),
    .key_code(key_code),
    .key_valid(key_valid),
    .digit_new(digit_new),
    .digit_old(digit_old),
    .busy(busy)
  );

  always_comb begin
    columns = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[rr*4+cc] && !rows[rr]) columns[cc] = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_kv(input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (key_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_busy(input logic val, input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (busy === val) ok = 1'b1;
    end
  endtask

  task automatic wait_rows(input logic [3:0] target, input int budget, output bit ok);
    int n;
    logic [3:0] prev;
    ok   = 1'b0;
    n    = 0;
    prev = rows;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (rows === target && prev !== target) ok = 1'b1;
      prev = rows;
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (key_valid === 1'b1) pulses++;
    end
  endtask

  task automatic do_reset();
    keys  = 16'h0000;
    reset = 1'b0;
    #3;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #10;
    checks++; if (rows !== 4'b1110) begin errors++; $display("FAIL reset_rows got %b want 1110", rows); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code got %h want 0", key_code); end
    checks++; if (digit_new !== 4'h0 || digit_old !== 4'h0) begin errors++; $display("FAIL reset_digits got %h/%h want 0/0", digit_new, digit_old); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_rows = ~(4'b0001 << ((i / 4) % 4));
      checks++; if (rows !== exp_rows) begin errors++; $display("FAIL idle_rows cycle %0d got %b want %b", i, rows, exp_rows); end
      checks++; if (key_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet cycle %0d got kv=%b busy=%b want 0/0", i, key_valid, busy); end
    end
  endtask

  task automatic test_clean_press();
    bit ok;
    int n;
    int pulses;
    keys[5] = 1'b1;                   // "5": row 1, column 1
    wait_busy(1'b1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL press5_detect got busy=%b want 1", busy); end
    wait_kv(40, ok, n);
    checks++; if (!ok || n != 17) begin errors++; $display("FAIL press5_latency got %0d cycles (ok=%0d) want 17", n, ok); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL press5_code got %h want 5", key_code); end
    checks++; if (digit_new !== 4'h5 || digit_old !== 4'h0) begin errors++; $display("FAIL press5_digits got %h/%h want 5/0", digit_new, digit_old); end
    count_pulses(22, pulses);
    checks++; if (pulses != 0) begin errors++; $display("FAIL press5_single got %0d extra pulses want 0", pulses); end
    checks++; if (rows !== 4'b1101 || busy !== 1'b1) begin errors++; $display("FAIL press5_hold got rows=%b busy=%b want 1101/1", rows, busy); end
    keys[5] = 1'b0;
    n = 0;
    while (rows === 4'b1101 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 18) begin errors++; $display("FAIL press5_release_time got %0d cycles want 18", n); end
    checks++; if (rows !== 4'b1011 || busy !== 1'b0) begin errors++; $display("FAIL press5_release_rows got rows=%b busy=%b want 1011/0", rows, busy); end
  endtask

  task automatic test_bouncy_press();
    bit ok;
    int n;
    int pulses;
    int p;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      keys[10] = ((i / 3) % 2) == 0;   // "9": row 2, column 2
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    keys[10] = 1'b1;
    wait_kv(200, ok, n);
    checks++; if (pulses != 0) begin errors++; $display("FAIL bounce9_early got %0d pulses want 0", pulses); end
    checks++; if (!ok || key_code !== 4'h9) begin errors++; $display("FAIL bounce9_code got %h (ok=%0d) want 9", key_code, ok); end
    checks++; if (digit_new !== 4'h9 || digit_old !== 4'h5) begin errors++; $display("FAIL bounce9_digits got %h/%h want 9/5", digit_new, digit_old); end
    count_pulses(20, p);
    pulses = p;
    for (int i = 0; i < 30; i++) begin
      keys[10] = ((i / 3) % 2) == 1;
      tick();
      if (key_valid === 1'b1) pulses++;
    end
    keys[10] = 1'b0;
    count_pulses(60, p);
    pulses += p;
    checks++; if (pulses != 0) begin errors++; $display("FAIL bounce9_release got %0d pulses want 0", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bounce9_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_sequence();
    bit ok;
    int n;
    logic [15:0] press [4];
    logic [3:0]  exp_new [4];
    logic [3:0]  exp_old [4];
    press   = '{16'h0001, 16'h0008, 16'h2000, 16'h0009};
    exp_new = '{4'h1, 4'hA, 4'h0, 4'h1};
    exp_old = '{4'h0, 4'h1, 4'hA, 4'h0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      keys = press[k];
      wait_kv(200, ok, n);
      checks++; if (!ok || key_code !== exp_new[k]) begin errors++; $display("FAIL seq%0d_code got %h (ok=%0d) want %h", k, key_code, ok, exp_new[k]); end
      checks++; if (digit_new !== exp_new[k] || digit_old !== exp_old[k]) begin errors++; $display("FAIL seq%0d_digits got %h/%h want %h/%h", k, digit_new, digit_old, exp_new[k], exp_old[k]); end
      keys = 16'h0000;
      wait_busy(1'b0, 60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq%0d_release got busy=%b want 0", k, busy); end
      if (k == 2) do_reset();   // last step starts from an empty history
    end
  endtask

  task automatic test_glitch();
    bit ok;
    int n;
    int pulses;
    wait_rows(4'b1011, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL glitch_row2 got rows=%b want 1011", rows); end
    keys[8] = 1'b1;                   // "7": row 2, column 0
    count_pulses(10, pulses);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_debounce got busy=%b want 1", busy); end
    keys[8] = 1'b0;
    n = 0;
    while (rows === 4'b1011 && n < 20) begin
      tick();
      n++;
      if (key_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulse got %0d pulses want 0", pulses); end
    checks++; if (rows !== 4'b0111 || busy !== 1'b0) begin errors++; $display("FAIL glitch_resume got rows=%b busy=%b want 0111/0", rows, busy); end
  endtask

  task automatic test_reset_in_hold();
    bit ok;
    int n;
    int pulses;
    keys[5] = 1'b1;
    wait_kv(200, ok, n);
    checks++; if (!ok || key_code !== 4'h5) begin errors++; $display("FAIL hold_first got %h (ok=%0d) want 5", key_code, ok); end
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rows !== 4'b1110 || busy !== 1'b0 || key_valid !== 1'b0) begin errors++; $display("FAIL hold_reset_ctrl got rows=%b busy=%b kv=%b want 1110/0/0", rows, busy, key_valid); end
    checks++; if (key_code !== 4'h0 || digit_new !== 4'h0 || digit_old !== 4'h0) begin errors++; $display("FAIL hold_reset_data got %h %h/%h want 0 0/0", key_code, digit_new, digit_old); end
    tick(); tick();
    reset = 1'b1;
    wait_busy(1'b1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_redetect got busy=%b want 1", busy); end
    wait_kv(40, ok, n);
    checks++; if (!ok || n != 17) begin errors++; $display("FAIL hold_relatency got %0d cycles (ok=%0d) want 17", n, ok); end
    checks++; if (key_code !== 4'h5 || digit_new !== 4'h5 || digit_old !== 4'h0) begin errors++; $display("FAIL hold_reaccept got %h %h/%h want 5 5/0", key_code, digit_new, digit_old); end
    count_pulses(40, pulses);
    checks++; if (pulses != 0) begin errors++; $display("FAIL hold_single got %0d extra pulses want 0", pulses); end
    keys = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_sequence();
    test_glitch();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencer for the 4x4 matrix keypad front end. Walks one-cold row strobes with a programmable settle time, samples the synchronized active-low columns, and debounces a press over a programmable window. Emits exactly one `key_valid` pulse and hex code per physical press, then locks out until the key has been released and debounced. Maintains a two-digit history (newest/older) that feeds the dual seven-segment display path.

## Interface
- `SETTLE_CYCLES`, default 4800: clk cycles a row is driven before columns are sampled (100 us at 48 MHz); minimum 2.
- `DEBOUNCE_CYCLES`, default 960000: clk cycles of stable level required for press and release (20 ms at 48 MHz); minimum 2.
- `clk` input 1: system clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `columns` input 4: keypad columns, active-low, asynchronous to `clk`.
- `rows` output 4: row strobes, one-cold (active-low); exactly one bit low at all times.
- `key_code` output 4: hex value of the last accepted key; holds until the next accept.
- `key_valid` output 1: one-cycle pulse on accept.
- `digit_new` output 4: most recent accepted key.
- `digit_old` output 4: key accepted before `digit_new`.
- `busy` output 1: high in DEBOUNCE, PRESSED and HOLD.

## Operation
- `columns` passes through a 2-flop synchronizer; all decisions use the synchronized value `col_s`.
- Row index `r` is 2 bits; `rows = ~(4'b0001 << r)`. The index wraps from 3 to 0.
- Counter `cnt` is wide enough for `max(SETTLE_CYCLES, DEBOUNCE_CYCLES)`. It clears on every state entry and on every restart condition.
- Key map (row r, col c lowest bit = c0):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- SCAN: hold row `r` and count.
  - At `cnt == SETTLE_CYCLES-1`, if `col_s == 4'b1111`: `r` increments and SCAN re-enters.
  - Otherwise, capture `cap = col_s` and go to DEBOUNCE, keeping `r`.
- DEBOUNCE: hold row `r`.
  - If `col_s != cap`: `cnt` clears. If `col_s == 4'b1111` as well, return to SCAN with `r` incremented.
  - At `cnt == DEBOUNCE_CYCLES-1` with `col_s == cap`: go to PRESSED.
- PRESSED (1 cycle):
  - Decode `(r, lowest-index zero bit of cap)` to `key_code`.
  - Pulse `key_valid`.
  - Shift the history: `digit_old <= digit_new`, `digit_new <= code`.
  - Go to HOLD.
- HOLD: hold row `r`.
  - `cnt` counts only while `col_s == 4'b1111`. Any low column clears `cnt`.
  - At `cnt == DEBOUNCE_CYCLES-1`: go to SCAN with `r` incremented.
- Multiple keys:
  - Several columns low in the same row: the lowest column index wins.
  - Keys in other rows are invisible until HOLD exits.
  - A second key added during DEBOUNCE changes `cap` equality and restarts the count.
- Reset mid-operation aborts any state. No `key_valid` is emitted, and the history clears.

## Timing
- Reset values:
  - state SCAN, `r` = 0, `rows` = 4'b1110
  - `key_code`, `digit_new`, `digit_old` = 0
  - `key_valid` = 0, `busy` = 0
  - `cnt` = 0, `cap` = 4'b1111, synchronizer flops = 4'b1111
- Idle scan period per row is exactly `SETTLE_CYCLES` clocks; a full sweep is `4*SETTLE_CYCLES`.
- Press latency: `key_valid` asserts `DEBOUNCE_CYCLES+1` clocks after DEBOUNCE entry, given stable input. The column change itself adds 2 synchronizer clocks plus up to one sweep.
- `key_code`, `digit_new` and `digit_old` update on the same edge that raises `key_valid`. They are valid while `key_valid` is high and thereafter.
- `key_valid` is high for exactly one clock per accepted press. It never reasserts without a full release debounce in between.
- `rows` changes only on SCAN-to-SCAN advance or HOLD/DEBOUNCE exit to SCAN; it never glitches to all-high or multi-low.

## Test plan
(Bench parameters: `SETTLE_CYCLES`=4, `DEBOUNCE_CYCLES`=16.)
- Reset/idle: hold `reset` low, then release with `columns` = 4'b1111 → `rows` cycles 1110, 1101, 1011, 0111 every 4 clocks; `key_valid` stays 0.
- Clean press of "5" (c1 low when `rows` = 1101) held 40 clocks → exactly one `key_valid` pulse with `key_code` = 5, `digit_new` = 5, `digit_old` = 0. `rows` stays 1101 until release plus 16 clocks.
- Bouncy press of "9": c2 toggles every 3 clocks for 30 clocks, then is stable → exactly one pulse with `key_code` = 9. Bounce on release also produces no second pulse.
- Sequence "1", "A", "0" → `digit_new`/`digit_old` progress 1/0, A/1, 0/A. Pressing c0 and c3 in row 0 together yields 1.
- Short glitch: c0 low for 10 clocks in row 2 → no `key_valid`, and scanning resumes at row 3.
- Assert `reset` asynchronously in HOLD after a press → outputs take their reset values immediately. A key still held after reset release is accepted once, at the new debounce time.
